// File: rtl/lcd_controller_pkg.sv
// Shared definitions for the LCD panel controller: command codes, RS encodings
// and the sequencer state enumeration.
package lcd_controller_pkg;

    localparam logic [7:0] CMD_SLEEP_OUT  = 8'h11;
    localparam logic [7:0] CMD_COL_ADDR   = 8'h2A;
    localparam logic [7:0] CMD_PAGE_ADDR  = 8'h2B;
    localparam logic [7:0] CMD_MEM_WRITE  = 8'h2C;

    localparam logic RS_CMD  = 1'b0;
    localparam logic RS_DATA = 1'b1;

    typedef enum logic [3:0] {
        RST_HOLD,
        SEND_START,
        START_WAIT,
        IDLE,
        COL_CMD,
        X0M,
        X0L,
        X1M,
        X1L,
        PAGE_CMD,
        Y0M,
        Y0L,
        Y1M,
        Y1L,
        MEM_CMD,
        PIXELS
    } state_t;

endpackage

// File: rtl/lcd_controller_if.sv
// Host-side handshakes of the LCD controller: fill rectangle and pixel stream.
interface lcd_controller_if #(
    parameter int CoordinateWidth = 9,
    parameter int PixelWidth      = 16
);
    logic [CoordinateWidth-1:0] rect_x0;
    logic [CoordinateWidth-1:0] rect_y0;
    logic [CoordinateWidth-1:0] rect_x1;
    logic [CoordinateWidth-1:0] rect_y1;
    logic                       rect_valid;
    logic                       rect_ready;
    logic [PixelWidth-1:0]      pixel_data;
    logic                       pixel_valid;
    logic                       pixel_ready;

    modport master (
        output rect_x0, rect_y0, rect_x1, rect_y1, rect_valid,
        output pixel_data, pixel_valid,
        input  rect_ready, pixel_ready
    );

    modport slave (
        input  rect_x0, rect_y0, rect_x1, rect_y1, rect_valid,
        input  pixel_data, pixel_valid,
        output rect_ready, pixel_ready
    );
endinterface

// File: rtl/lcd_bus_writer.sv
// Two-cycle parallel bus write: lcd_wr low with bus driven, then lcd_wr high with
// bus held; the panel latches on the lcd_wr rising edge.
module lcd_bus_writer #(
    parameter int DataWidth = 18
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 rs,
    input  logic [DataWidth-1:0] data,
    output logic                 ready,
    output logic                 lcd_wr,
    output logic                 lcd_rs,
    output logic [DataWidth-1:0] lcd_db
);

    // The high-phase cycle doubles as the accept slot for the next write.
    assign ready = lcd_wr;

    always_ff @(posedge clock) begin
        if (reset) begin
            lcd_wr <= 1'b1;
            lcd_rs <= 1'b0;
            lcd_db <= '0;
        end else if (!lcd_wr) begin
            lcd_wr <= 1'b1;
        end else if (start) begin
            lcd_wr <= 1'b0;
            lcd_rs <= rs;
            lcd_db <= data;
        end
    end

endmodule

// File: rtl/lcd_controller.sv
// LCD panel controller: reset/wake-up sequencing, then address-window setup and
// pixel streaming for each accepted fill rectangle.
//
// state      | meaning
// RST_HOLD   | lcd_rst held low for ResetCycles
// SEND_START | issue sleep-out command 0x11
// START_WAIT | StartupDelay silent cycles after 0x11
// IDLE       | accept and check a rectangle
// COL_CMD..  | 0x2A + four x bytes
// PAGE_CMD.. | 0x2B + four y bytes
// MEM_CMD    | 0x2C memory write command
// PIXELS     | one data write per accepted pixel
module lcd_controller
    import lcd_controller_pkg::*;
#(
    parameter int Width           = 480,
    parameter int Height          = 320,
    parameter int CoordinateWidth = 9,
    parameter int DataWidth       = 18,
    parameter int PixelWidth      = 16,
    parameter int ResetCycles     = 4,
    parameter int StartupDelay    = 1000
) (
    input  logic                 clock,
    input  logic                 reset,
    lcd_controller_if.slave      host,
    output logic                 busy,
    output logic                 error,
    output logic [DataWidth-1:0] lcd_db,
    output logic                 lcd_wr,
    output logic                 lcd_rs,
    output logic                 lcd_cs,
    output logic                 lcd_rd,
    output logic                 lcd_rst,
    output logic                 lcd_blen
);

    localparam int CW   = CoordinateWidth;
    localparam int NW   = 2 * CW + 2;
    localparam int TMAX = (ResetCycles > StartupDelay) ? ResetCycles : StartupDelay;
    localparam int TW   = $clog2(TMAX + 2);
    localparam logic [CW:0] W_LIM = (CW + 1)'(Width);
    localparam logic [CW:0] H_LIM = (CW + 1)'(Height);

    state_t               state;
    state_t               state_adv;
    logic [TW-1:0]        tmr;
    logic [CW-1:0]        x0_q, y0_q, x1_q, y1_q;
    logic [15:0]          x0_w, y0_w, x1_w, y1_w;
    logic [NW-1:0]        remaining;
    logic [CW:0]          rect_w, rect_h;
    logic                 legal;
    logic                 is_write;
    logic                 px_xfer;
    logic                 wr_ready;
    logic                 wr_start;
    logic                 wr_rs;
    logic [DataWidth-1:0] wr_data;

    assign x0_w = 16'(x0_q);
    assign x1_w = 16'(x1_q);
    assign y0_w = 16'(y0_q);
    assign y1_w = 16'(y1_q);

    assign legal = (host.rect_x0 <= host.rect_x1) && ({1'b0, host.rect_x1} < W_LIM) &&
                   (host.rect_y0 <= host.rect_y1) && ({1'b0, host.rect_y1} < H_LIM);
    assign rect_w = {1'b0, host.rect_x1} - {1'b0, host.rect_x0} + (CW + 1)'(1);
    assign rect_h = {1'b0, host.rect_y1} - {1'b0, host.rect_y0} + (CW + 1)'(1);

    assign host.rect_ready  = (state == IDLE);
    assign host.pixel_ready = (state == PIXELS) && wr_ready && (remaining != '0);
    assign px_xfer  = host.pixel_ready && host.pixel_valid;
    assign wr_start = (wr_ready && is_write) || px_xfer;

    assign busy   = (state != IDLE);
    assign lcd_cs = (state == IDLE) || (state == RST_HOLD);
    assign lcd_rd = 1'b1;

    always_comb begin
        is_write  = 1'b0;
        wr_rs     = RS_DATA;
        wr_data   = '0;
        state_adv = state;
        case (state)
            SEND_START: begin is_write = 1'b1; wr_rs = RS_CMD; wr_data = DataWidth'(CMD_SLEEP_OUT); state_adv = START_WAIT; end
            COL_CMD:    begin is_write = 1'b1; wr_rs = RS_CMD; wr_data = DataWidth'(CMD_COL_ADDR);  state_adv = X0M; end
            X0M:        begin is_write = 1'b1; wr_data = DataWidth'(x0_w[15:8]); state_adv = X0L; end
            X0L:        begin is_write = 1'b1; wr_data = DataWidth'(x0_w[7:0]);  state_adv = X1M; end
            X1M:        begin is_write = 1'b1; wr_data = DataWidth'(x1_w[15:8]); state_adv = X1L; end
            X1L:        begin is_write = 1'b1; wr_data = DataWidth'(x1_w[7:0]);  state_adv = PAGE_CMD; end
            PAGE_CMD:   begin is_write = 1'b1; wr_rs = RS_CMD; wr_data = DataWidth'(CMD_PAGE_ADDR); state_adv = Y0M; end
            Y0M:        begin is_write = 1'b1; wr_data = DataWidth'(y0_w[15:8]); state_adv = Y0L; end
            Y0L:        begin is_write = 1'b1; wr_data = DataWidth'(y0_w[7:0]);  state_adv = Y1M; end
            Y1M:        begin is_write = 1'b1; wr_data = DataWidth'(y1_w[15:8]); state_adv = Y1L; end
            Y1L:        begin is_write = 1'b1; wr_data = DataWidth'(y1_w[7:0]);  state_adv = MEM_CMD; end
            MEM_CMD:    begin is_write = 1'b1; wr_rs = RS_CMD; wr_data = DataWidth'(CMD_MEM_WRITE); state_adv = PIXELS; end
            PIXELS:     wr_data = DataWidth'(host.pixel_data);
            default:    ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RST_HOLD;
            tmr       <= '0;
            lcd_rst   <= 1'b0;
            lcd_blen  <= 1'b0;
            error     <= 1'b0;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            remaining <= '0;
        end else begin
            error <= 1'b0;
            case (state)
                RST_HOLD: begin
                    if (tmr == TW'(ResetCycles)) begin
                        lcd_rst <= 1'b1;
                        tmr     <= '0;
                        state   <= SEND_START;
                    end else begin
                        tmr <= tmr + TW'(1);
                    end
                end
                // Silence is counted from the high phase of the 0x11 write.
                START_WAIT: begin
                    if (wr_ready) begin
                        if (tmr == TW'(StartupDelay)) begin
                            tmr      <= '0;
                            lcd_blen <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            tmr <= tmr + TW'(1);
                        end
                    end
                end
                IDLE: begin
                    if (host.rect_valid) begin
                        if (legal) begin
                            x0_q      <= host.rect_x0;
                            y0_q      <= host.rect_y0;
                            x1_q      <= host.rect_x1;
                            y1_q      <= host.rect_y1;
                            remaining <= NW'(rect_w) * NW'(rect_h);
                            state     <= COL_CMD;
                        end else begin
                            error <= 1'b1;
                        end
                    end
                end
                PIXELS: begin
                    if (px_xfer) begin
                        remaining <= remaining - NW'(1);
                    end else if ((remaining == '0) && wr_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (wr_ready) state <= state_adv;
                end
            endcase
        end
    end

    lcd_bus_writer #(
        .DataWidth(DataWidth)
    ) u_writer (
        .clock  (clock),
        .reset  (reset),
        .start  (wr_start),
        .rs     (wr_rs),
        .data   (wr_data),
        .ready  (wr_ready),
        .lcd_wr (lcd_wr),
        .lcd_rs (lcd_rs),
        .lcd_db (lcd_db)
    );

endmodule
